// File: rtl/cpu_bus_pkg.sv
// Shared types and constants for the data-RAM bus: arbiter states, default widths, requester indices.
package cpu_bus_pkg;
   typedef enum logic {ARB = 1'b0, LOCKED = 1'b1} arb_state_t;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int REQ_CPU    = 0;
   localparam int REQ_IO     = 1;

   function automatic int wrap_inc(input int i, input int n);
      return (i + 1 >= n) ? 0 : i + 1;
   endfunction
endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: packed per-requester requests, grants and read responses.
interface ram_arbiter_if #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_we;
   logic [NUM_REQ-1:0]        req_lock;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ*DATA_W-1:0] req_wdata;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_rdata;

   modport master (output req_valid, req_we, req_lock, req_addr, req_wdata,
                   input  req_ready, rsp_valid, rsp_rdata);
   modport slave  (input  req_valid, req_we, req_lock, req_addr, req_wdata,
                   output req_ready, rsp_valid, rsp_rdata);
endinterface

// File: rtl/ram_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible request at or after ptr, wrapping modulo N.
module rr_picker import cpu_bus_pkg::*; #(
   parameter int N  = 2,
   parameter int IW = 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic [N-1:0]  mask,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [N-1:0] elig;
   assign elig = req & mask;

   always_comb begin
      logic [IW-1:0] j;
      j     = '0;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = IW'((int'(ptr) + k) % N);
         if (!any && elig[j]) begin
            any      = 1'b1;
            grant[j] = 1'b1;
            idx      = j;
         end
      end
   end
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ requesters, with lock and lock timeout.
module ram_arbiter import cpu_bus_pkg::*; #(
   parameter int NUM_REQ      = 2,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int LOCK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   ram_arbiter_if.slave      bus,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              lock_timeout
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   arb_state_t          state, state_d;
   logic [IW-1:0]       prio_ptr, ptr_d, owner, owner_d, win_idx;
   logic [CW-1:0]       cnt, cnt_d;
   logic [NUM_REQ-1:0]  mask, grant, rsp_q, rsp_d;
   logic                win_any, win_live, accept;

   assign mask = (state == LOCKED) ? (NUM_REQ'(1) << owner) : '1;

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
      .req   (bus.req_valid),
      .ptr   (prio_ptr),
      .mask  (mask),
      .grant (grant),
      .idx   (win_idx),
      .any   (win_any)
   );

   // Reset blanks grants immediately, not just at the next edge.
   assign win_live      = win_any & ~rst;
   assign accept        = win_live & clk_en;
   assign bus.req_ready = rst ? '0 : grant;
   assign bus.rsp_valid = rsp_q;
   assign bus.rsp_rdata = mem_rdata;
   assign mem_en        = accept;

   always_comb begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (win_live) begin
         mem_we    = bus.req_we[win_idx];
         mem_addr  = bus.req_addr[win_idx*ADDR_W +: ADDR_W];
         mem_wdata = bus.req_wdata[win_idx*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      state_d      = state;
      ptr_d        = prio_ptr;
      owner_d      = owner;
      cnt_d        = cnt;
      rsp_d        = '0;
      lock_timeout = 1'b0;
      if (accept && !bus.req_we[win_idx])
         rsp_d = grant;
      case (state)
         ARB: begin
            if (accept) begin
               ptr_d = IW'(wrap_inc(int'(win_idx), NUM_REQ));
               if (bus.req_lock[win_idx]) begin
                  state_d = LOCKED;
                  owner_d = win_idx;
                  cnt_d   = '0;
               end
            end
         end
         LOCKED: begin
            // Only the owner can be accepted here; a real access always beats the timeout.
            if (accept) begin
               cnt_d = '0;
               if (!bus.req_lock[win_idx]) begin
                  state_d = ARB;
                  ptr_d   = IW'(wrap_inc(int'(owner), NUM_REQ));
               end
            end else if (clk_en) begin
               cnt_d = cnt + 1'b1;
               if (LOCK_TIMEOUT != 0 && int'(cnt) + 1 >= LOCK_TIMEOUT) begin
                  state_d      = ARB;
                  cnt_d        = '0;
                  ptr_d        = IW'(wrap_inc(int'(owner), NUM_REQ));
                  lock_timeout = 1'b1;
               end
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ARB;
         prio_ptr <= '0;
         owner    <= '0;
         cnt      <= '0;
         rsp_q    <= '0;
      end else if (clk_en) begin
         state    <= state_d;
         prio_ptr <= ptr_d;
         owner    <= owner_d;
         cnt      <= cnt_d;
         rsp_q    <= rsp_d;
      end
   end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed, table-driven bench for ram_arbiter with a behavioural single-port RAM behind it.
module tb_ram_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic        clk_en;
   logic        mem_en, mem_we, lock_timeout;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] ram [0:65535];
   int          checks = 0;
   int          errors = 0;

   ram_arbiter_if #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16)) bus ();

   ram_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(16), .LOCK_TIMEOUT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .clk_en       (clk_en),
      .bus          (bus),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .lock_timeout (lock_timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (clk_en && mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic        en;
      logic [1:0]  v, we, lk;
      logic [15:0] a0, a1, d0, d1;
      logic [1:0]  rdy;
      logic        men, mwe;
      logic [15:0] maddr, mwd;
      logic [1:0]  rsp;
      logic [15:0] rdat;
      logic        to;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic en, input logic [1:0] v, we, lk,
                      input logic [15:0] a0, a1, d0, d1,
                      input logic [1:0] rdy, input logic men, mwe,
                      input logic [15:0] maddr, mwd,
                      input logic [1:0] rsp, input logic [15:0] rdat, input logic to);
      vec_t t;
      t.en = en; t.v = v; t.we = we; t.lk = lk;
      t.a0 = a0; t.a1 = a1; t.d0 = d0; t.d1 = d1;
      t.rdy = rdy; t.men = men; t.mwe = mwe; t.maddr = maddr; t.mwd = mwd;
      t.rsp = rsp; t.rdat = rdat; t.to = to;
      vecs.push_back(t);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic en, input logic [1:0] v, we, lk,
                        input logic [15:0] a0, a1, d0, d1);
      clk_en        = en;
      bus.req_valid = v;
      bus.req_we    = we;
      bus.req_lock  = lk;
      bus.req_addr  = {a1, a0};
      bus.req_wdata = {d1, d0};
   endtask

   task automatic idle();
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, 0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);

      // v0: idle after reset
      idle();
      // v1-4: both write continuously, grants alternate 0,1,0,1
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0)
            add(1, 2'b11, 2'b11, 2'b00, 16'h0100, 16'h0200, 16'h1111, 16'h2222,
                2'b01, 1, 1, 16'h0100, 16'h1111, 2'b00, 16'h0, 0);
         else
            add(1, 2'b11, 2'b11, 2'b00, 16'h0100, 16'h0200, 16'h1111, 16'h2222,
                2'b10, 1, 1, 16'h0200, 16'h2222, 2'b00, 16'h0, 0);
      end
      // v5-9: write BEEF, then reads with one-cycle responses overlapping next grants
      add(1, 2'b01, 2'b01, 2'b00, 16'h0010, 16'h0, 16'hBEEF, 16'h0,
          2'b01, 1, 1, 16'h0010, 16'hBEEF, 2'b00, 16'h0, 0);
      add(1, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0,
          2'b01, 1, 0, 16'h0010, 16'h0, 2'b00, 16'h0, 0);
      add(1, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0100, 16'h0, 16'h0,
          2'b10, 1, 0, 16'h0100, 16'h0, 2'b01, 16'hBEEF, 0);
      add(1, 2'b01, 2'b00, 2'b00, 16'h0200, 16'h0, 16'h0, 16'h0,
          2'b01, 1, 0, 16'h0200, 16'h0, 2'b10, 16'h1111, 0);
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b01, 16'h2222, 0);
      // v10-13: req1 locked write then unlocking read; req0 waits throughout
      add(1, 2'b11, 2'b10, 2'b10, 16'h0010, 16'h0300, 16'h0, 16'hFFFF,
          2'b10, 1, 1, 16'h0300, 16'hFFFF, 2'b00, 16'h0, 0);
      add(1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0300, 16'h0, 16'h0,
          2'b10, 1, 0, 16'h0300, 16'h0, 2'b00, 16'h0, 0);
      add(1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0300, 16'h0, 16'h0,
          2'b01, 1, 0, 16'h0010, 16'h0, 2'b10, 16'hFFFF, 0);
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b01, 16'hBEEF, 0);
      // v14-20: req0 locks then idles; req1 blocked 4 cycles, pulse on 4th, granted on 5th
      add(1, 2'b01, 2'b01, 2'b01, 16'h0400, 16'h0, 16'h1234, 16'h0,
          2'b01, 1, 1, 16'h0400, 16'h1234, 2'b00, 16'h0, 0);
      for (int i = 0; i < 4; i++)
         add(1, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0400, 16'h0, 16'h0,
             2'b00, 0, 0, 16'h0, 16'h0, 2'b00, 16'h0, (i == 3));
      add(1, 2'b10, 2'b00, 2'b00, 16'h0, 16'h0400, 16'h0, 16'h0,
          2'b10, 1, 0, 16'h0400, 16'h0, 2'b00, 16'h0, 0);
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b10, 16'h1234, 0);
      // v21-27: unlocking access lands on the timeout cycle; access wins, no pulse
      add(1, 2'b01, 2'b01, 2'b01, 16'h0500, 16'h0, 16'h5555, 16'h0,
          2'b01, 1, 1, 16'h0500, 16'h5555, 2'b00, 16'h0, 0);
      for (int i = 0; i < 3; i++) idle();
      add(1, 2'b11, 2'b01, 2'b00, 16'h0500, 16'h0500, 16'h6666, 16'h0,
          2'b01, 1, 1, 16'h0500, 16'h6666, 2'b00, 16'h0, 0);
      add(1, 2'b11, 2'b01, 2'b00, 16'h0500, 16'h0500, 16'h6666, 16'h0,
          2'b10, 1, 0, 16'h0500, 16'h0, 2'b00, 16'h0, 0);
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b10, 16'h6666, 0);
      // v28-35: accepted read, 3 stalled cycles, response consumed once enabled
      add(1, 2'b01, 2'b00, 2'b00, 16'h0010, 16'h0, 16'h0, 16'h0,
          2'b01, 1, 0, 16'h0010, 16'h0, 2'b00, 16'h0, 0);
      for (int i = 0; i < 3; i++)
         add(0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0100, 16'h0, 16'h0,
             2'b10, 0, 0, 16'h0100, 16'h0, 2'b01, 16'hBEEF, 0);
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b01, 16'hBEEF, 0);
      idle();
      add(1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0100, 16'h0, 16'h0,
          2'b10, 1, 0, 16'h0100, 16'h0, 2'b00, 16'h0, 0);
      add(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0,
          2'b00, 0, 0, 16'h0, 16'h0, 2'b10, 16'h1111, 0);

      // Reset state while held
      repeat (2) @(negedge clk);
      drive(1, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0100, 16'h0, 16'h0);
      #1;
      chk("reset_rdy", 32'(bus.req_ready), 32'h0);
      chk("reset_rsp", 32'(bus.rsp_valid), 32'h0);
      chk("reset_men", 32'(mem_en), 32'h0);
      chk("reset_to",  32'(lock_timeout), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         if (i > 0) @(negedge clk);
         drive(vecs[i].en, vecs[i].v, vecs[i].we, vecs[i].lk,
               vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
         #1;
         chk($sformatf("v%0d_rdy", i),   32'(bus.req_ready), 32'(vecs[i].rdy));
         chk($sformatf("v%0d_men", i),   32'(mem_en),        32'(vecs[i].men));
         chk($sformatf("v%0d_mwe", i),   32'(mem_we),        32'(vecs[i].mwe));
         chk($sformatf("v%0d_maddr", i), 32'(mem_addr),      32'(vecs[i].maddr));
         chk($sformatf("v%0d_mwd", i),   32'(mem_wdata),     32'(vecs[i].mwd));
         chk($sformatf("v%0d_rsp", i),   32'(bus.rsp_valid), 32'(vecs[i].rsp));
         chk($sformatf("v%0d_to", i),    32'(lock_timeout),  32'(vecs[i].to));
         if (vecs[i].rsp != 2'b00)
            chk($sformatf("v%0d_rdata", i), 32'(bus.rsp_rdata), 32'(vecs[i].rdat));
      end

      // Reset mid-LOCKED with a read response pending
      @(negedge clk);
      drive(1, 2'b10, 2'b00, 2'b10, 16'h0, 16'h0010, 16'h0, 16'h0);
      #1;
      chk("rl_lock_rdy", 32'(bus.req_ready), 32'h2);
      @(negedge clk);
      drive(1, 2'b11, 2'b00, 2'b10, 16'h0200, 16'h0010, 16'h0, 16'h0);
      #1;
      chk("rl_pend_rsp", 32'(bus.rsp_valid), 32'h2);
      chk("rl_pend_rdata", 32'(bus.rsp_rdata), 32'hBEEF);
      chk("rl_owner_rdy", 32'(bus.req_ready), 32'h2);
      rst = 1'b1;
      #1;
      chk("rl_rst_rsp", 32'(bus.rsp_valid), 32'h0);
      chk("rl_rst_rdy", 32'(bus.req_ready), 32'h0);
      chk("rl_rst_men", 32'(mem_en), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 2'b10, 2'b00, 2'b00, 16'h0200, 16'h0010, 16'h0, 16'h0);
      #1;
      chk("rl_req1_rdy", 32'(bus.req_ready), 32'h2);
      chk("rl_req1_addr", 32'(mem_addr), 32'h0010);
      @(negedge clk);
      drive(1, 2'b11, 2'b00, 2'b00, 16'h0200, 16'h0010, 16'h0, 16'h0);
      #1;
      chk("rl_both_rdy", 32'(bus.req_ready), 32'h1);
      chk("rl_rsp", 32'(bus.rsp_valid), 32'h2);
      chk("rl_rdata", 32'(bus.rsp_rdata), 32'hBEEF);

      @(negedge clk);
      drive(1, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
